maze_game_ctrl: RTL and testbench

// Top-level game sequencer for the maze design. Owns the game state
// (WELCOME/PLAY/WIN/LOSE), the selected level number, and the play countdown.

---
 rtl/maze_pkg.sv | 19 +
 rtl/btn_edge.sv | 27 ++
 rtl/maze_game_ctrl.sv | 114 +++++++++++
 tb/tb_maze_game_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings and widths for the maze game sequencer.
// WELCOME must remain 2'b00 because existing screen logic decodes it.
package maze_pkg;

  localparam int LEVEL_W = 5;
  localparam int TIME_W  = 8;
  localparam int WIN_W   = 8;
  localparam int HOLD_W  = 8;

  localparam logic [1:0] ST_WELCOME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_WIN     = 2'b10;
  localparam logic [1:0] ST_LOSE    = 2'b11;

  function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] v);
    return (v == {WIN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// press is combinational off the registered history; a held button yields one press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Game sequencer: WELCOME/PLAY/WIN/LOSE, level select, run countdown, hold timer.
// All outputs registered, one clock from inputs.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int LEVEL_MAX     = 19,
  parameter int LEVEL_DEFAULT = 10,
  parameter int TIME_LIMIT    = 60,
  parameter int HOLD_TICKS    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_start,
  input  logic               goal_reached,
  output logic [1:0]         state,
  output logic [LEVEL_W-1:0] level_num,
  output logic [TIME_W-1:0]  time_left,
  output logic               load_maze,
  output logic [WIN_W-1:0]   win_count
);

  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_DEF   = LEVEL_W'(LEVEL_DEFAULT);
  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(TIME_LIMIT);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic up_press, down_press, start_press;

  btn_edge u_up    (.clk(clk), .rst(rst), .btn(btn_up),    .press(up_press));
  btn_edge u_down  (.clk(clk), .rst(rst), .btn(btn_down),  .press(down_press));
  btn_edge u_start (.clk(clk), .rst(rst), .btn(btn_start), .press(start_press));

  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TIME_W-1:0]  time_q,  time_d;
  logic               load_q,  load_d;
  logic [WIN_W-1:0]   win_q,   win_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    time_d  = time_q;
    load_d  = 1'b0;
    win_d   = win_q;
    hold_d  = hold_q;
    case (state_q)
      ST_WELCOME: begin
        if (start_press) begin
          state_d = ST_PLAY;
          time_d  = TIME_INIT;
          load_d  = 1'b1;
        end else if (up_press && !down_press) begin
          if (level_q < LVL_MAX) level_d = level_q + 1'b1;
        end else if (down_press && !up_press) begin
          if (level_q != '0) level_d = level_q - 1'b1;
        end
      end
      ST_PLAY: begin
        // A goal in the same cycle as the final tick counts as a win; the clock stops.
        if (goal_reached) begin
          state_d = ST_WIN;
          win_d   = sat_inc(win_q);
          hold_d  = '0;
        end else if (tick_1hz) begin
          if (time_q > TIME_W'(1)) begin
            time_d = time_q - 1'b1;
          end else begin
            time_d  = '0;
            state_d = ST_LOSE;
            hold_d  = '0;
          end
        end
      end
      default: begin
        if (start_press || (tick_1hz && hold_q == HOLD_LAST)) begin
          state_d = ST_WELCOME;
          hold_d  = '0;
          if (state_q == ST_WIN && level_q < LVL_MAX) level_d = level_q + 1'b1;
        end else if (tick_1hz) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WELCOME;
      level_q <= LVL_DEF;
      time_q  <= TIME_INIT;
      load_q  <= 1'b0;
      win_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      time_q  <= time_d;
      load_q  <= load_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
    end
  end

  assign state     = state_q;
  assign level_num = level_q;
  assign time_left = time_q;
  assign load_maze = load_q;
  assign win_count = win_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed scenarios followed by random button/tick traffic, all checked
// cycle by cycle against a game-rule reference model.
module tb_maze_game_ctrl;
  import maze_pkg::*;

  logic               clk = 1'b0;
  logic               rst, tick_1hz, btn_up, btn_down, btn_start, goal_reached;
  logic [1:0]         state;
  logic [LEVEL_W-1:0] level_num;
  logic [TIME_W-1:0]  time_left;
  logic               load_maze;
  logic [WIN_W-1:0]   win_count;

  int tests = 0;
  int fails = 0;

  // Reference model: game state as plain integers
  int m_state, m_level, m_time, m_load, m_wins, m_hold;
  bit p_up, p_down, p_start;

  maze_game_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_up(btn_up),
    .btn_down(btn_down), .btn_start(btn_start), .goal_reached(goal_reached),
    .state(state), .level_num(level_num), .time_left(time_left),
    .load_maze(load_maze), .win_count(win_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit u, input bit d, input bit s, input bit g, input bit t);
    bit up_p, dn_p, st_p;
    up_p = u && !p_up;
    dn_p = d && !p_down;
    st_p = s && !p_start;
    m_load = 0;
    if (r) begin
      m_state = 0; m_level = 10; m_time = 60; m_wins = 0; m_hold = 0;
      p_up = 0; p_down = 0; p_start = 0;
      return;
    end
    if (m_state == 0) begin
      if (st_p) begin
        m_state = 1; m_time = 60; m_load = 1;
      end else if (up_p && !dn_p) m_level = (m_level < 19) ? m_level + 1 : m_level;
      else if (dn_p && !up_p)     m_level = (m_level > 0) ? m_level - 1 : 0;
    end else if (m_state == 1) begin
      if (g) begin
        m_state = 2; m_hold = 0;
        m_wins = (m_wins < 255) ? m_wins + 1 : 255;
      end else if (t) begin
        m_time = m_time - 1;
        if (m_time == 0) begin m_state = 3; m_hold = 0; end
      end
    end else begin
      if (t) m_hold = m_hold + 1;
      if (st_p || m_hold >= 5) begin
        if (m_state == 2 && m_level < 19) m_level = m_level + 1;
        m_state = 0; m_hold = 0;
      end
    end
    p_up = u; p_down = d; p_start = s;
  endtask

  task automatic step(input bit r, input bit u, input bit d, input bit s, input bit g, input bit t);
    rst = r; btn_up = u; btn_down = d; btn_start = s; goal_reached = g; tick_1hz = t;
    @(posedge clk);
    model(r, u, d, s, g, t);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("level_num", 32'(level_num), 32'(m_level));
    check("time_left", 32'(time_left), 32'(m_time));
    check("load_maze", 32'(load_maze), 32'(m_load));
    check("win_count", 32'(win_count), 32'(m_wins));
    @(negedge clk);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
  task automatic press_up();    step(0, 1, 0, 0, 0, 0); idle(); endtask
  task automatic press_down();  step(0, 0, 1, 0, 0, 0); idle(); endtask
  task automatic press_start(); step(0, 0, 0, 1, 0, 0); idle(); endtask
  task automatic tick();        step(0, 0, 0, 0, 0, 1); idle(); endtask

  initial begin
    bit ru, rd, rs, rg, rt, rr;
    rst = 1; btn_up = 0; btn_down = 0; btn_start = 0; goal_reached = 0; tick_1hz = 0;

    // 1: reset values, three presses, held button counts once
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_state", 32'(state), 32'(ST_WELCOME));
    check("rst_level", 32'(level_num), 32'd10);
    check("rst_time", 32'(time_left), 32'd60);
    check("rst_load", 32'(load_maze), 32'd0);
    check("rst_wins", 32'(win_count), 32'd0);
    idle();
    repeat (3) press_up();
    check("up3_level", 32'(level_num), 32'd13);
    repeat (20) step(0, 1, 0, 0, 0, 0);
    idle();
    check("hold_up_level", 32'(level_num), 32'd14);

    // 2: saturate at top and bottom
    repeat (4) press_up();
    check("lvl18", 32'(level_num), 32'd18);
    repeat (3) press_up();
    check("lvl_top_sat", 32'(level_num), 32'd19);
    repeat (18) press_down();
    check("lvl1", 32'(level_num), 32'd1);
    repeat (3) press_down();
    check("lvl_bot_sat", 32'(level_num), 32'd0);
    step(0, 1, 1, 0, 0, 0);
    idle();
    check("up_dn_same", 32'(level_num), 32'd0);
    repeat (3) press_up();

    // 3: start beats a same-cycle up press
    step(0, 1, 0, 1, 0, 0);
    check("start_state", 32'(state), 32'(ST_PLAY));
    check("start_load", 32'(load_maze), 32'd1);
    check("start_level", 32'(level_num), 32'd3);
    idle();
    check("load_one_clk", 32'(load_maze), 32'd0);

    // 4: timeout, then auto-return after hold
    repeat (59) tick();
    check("time_one", 32'(time_left), 32'd1);
    tick();
    check("lose_state", 32'(state), 32'(ST_LOSE));
    check("lose_time", 32'(time_left), 32'd0);
    repeat (4) tick();
    check("lose_hold4", 32'(state), 32'(ST_LOSE));
    tick();
    check("lose_exit", 32'(state), 32'(ST_WELCOME));
    check("lose_level", 32'(level_num), 32'd3);

    // 5: win at level 19 on the final tick, start returns early
    repeat (19) press_up();
    press_start();
    repeat (59) tick();
    step(0, 0, 0, 0, 1, 1);
    check("win_state", 32'(state), 32'(ST_WIN));
    check("win_count1", 32'(win_count), 32'd1);
    idle();
    press_start();
    check("win_exit", 32'(state), 32'(ST_WELCOME));
    check("win_level19", 32'(level_num), 32'd19);

    // 6: reset mid-run
    press_start();
    repeat (30) tick();
    check("mid_time30", 32'(time_left), 32'd30);
    step(1, 0, 0, 0, 0, 0);
    check("mid_rst_state", 32'(state), 32'(ST_WELCOME));
    check("mid_rst_level", 32'(level_num), 32'd10);
    check("mid_rst_time", 32'(time_left), 32'd60);
    check("mid_rst_wins", 32'(win_count), 32'd0);

    // Random traffic; goal never coincides with a tick here
    ru = 0; rd = 0; rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) ru = ~ru;
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      if ($urandom_range(0, 9) == 0) rs = ~rs;
      rt = ($urandom_range(0, 2) == 0);
      rg = !rt && ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 699) == 0);
      step(rr, ru, rd, rs, rg, rt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
